// File: rtl/alu_mc_pkg.sv
// Shared ALU operation codes and shifter types for the kianV multicycle ALU.
package alu_mc_pkg;

  localparam int ALU_CTRL_WIDTH = 5;

  localparam logic [ALU_CTRL_WIDTH-1:0] ALU_CTRL_ADD  = 5'd0;
  localparam logic [ALU_CTRL_WIDTH-1:0] ALU_CTRL_SUB  = 5'd1;
  localparam logic [ALU_CTRL_WIDTH-1:0] ALU_CTRL_AND  = 5'd2;
  localparam logic [ALU_CTRL_WIDTH-1:0] ALU_CTRL_OR   = 5'd3;
  localparam logic [ALU_CTRL_WIDTH-1:0] ALU_CTRL_XOR  = 5'd4;
  localparam logic [ALU_CTRL_WIDTH-1:0] ALU_CTRL_SLT  = 5'd5;
  localparam logic [ALU_CTRL_WIDTH-1:0] ALU_CTRL_SLTU = 5'd6;
  localparam logic [ALU_CTRL_WIDTH-1:0] ALU_CTRL_SLL  = 5'd7;
  localparam logic [ALU_CTRL_WIDTH-1:0] ALU_CTRL_SRL  = 5'd8;
  localparam logic [ALU_CTRL_WIDTH-1:0] ALU_CTRL_SRA  = 5'd9;
  localparam logic [ALU_CTRL_WIDTH-1:0] ALU_CTRL_LUI  = 5'd10;
  localparam logic [ALU_CTRL_WIDTH-1:0] ALU_CTRL_BEQ  = 5'd11;
  localparam logic [ALU_CTRL_WIDTH-1:0] ALU_CTRL_BNE  = 5'd12;
  localparam logic [ALU_CTRL_WIDTH-1:0] ALU_CTRL_BLT  = 5'd13;
  localparam logic [ALU_CTRL_WIDTH-1:0] ALU_CTRL_BGE  = 5'd14;
  localparam logic [ALU_CTRL_WIDTH-1:0] ALU_CTRL_BLTU = 5'd15;
  localparam logic [ALU_CTRL_WIDTH-1:0] ALU_CTRL_BGEU = 5'd16;
  localparam logic [ALU_CTRL_WIDTH-1:0] ALU_CTRL_ROL  = 5'd17;
  localparam logic [ALU_CTRL_WIDTH-1:0] ALU_CTRL_ROR  = 5'd18;
  localparam logic [ALU_CTRL_WIDTH-1:0] ALU_CTRL_MIN  = 5'd19;
  localparam logic [ALU_CTRL_WIDTH-1:0] ALU_CTRL_MAX  = 5'd20;
  localparam logic [ALU_CTRL_WIDTH-1:0] ALU_CTRL_MINU = 5'd21;
  localparam logic [ALU_CTRL_WIDTH-1:0] ALU_CTRL_MAXU = 5'd22;

  typedef enum logic [1:0] {ST_IDLE, ST_SHIFT, ST_DONE} shift_state_e;
  typedef enum logic [2:0] {SH_SLL, SH_SRL, SH_SRA, SH_ROL, SH_ROR} shift_op_e;

endpackage

// File: rtl/alu_shift_unit.sv
// Iterative shifter: moves the operand at most SHIFT_STEP bits per cycle and
// drops the work as soon as the request goes away or changes operation.
module alu_shift_unit
  import alu_mc_pkg::*;
#(
  parameter int XLEN       = 32,
  parameter int SHIFT_STEP = 4,
  localparam int SHAMT_W   = $clog2(XLEN)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               abort,
  input  shift_op_e          op,
  input  logic [XLEN-1:0]    data,
  input  logic [SHAMT_W-1:0] shamt,
  output logic               done,
  output logic [XLEN-1:0]    q
);

  localparam logic [SHAMT_W-1:0] STEP_C = SHAMT_W'(SHIFT_STEP);

  shift_state_e       state, state_nx;
  shift_op_e          op_q;
  logic [XLEN-1:0]    sreg;
  logic [SHAMT_W-1:0] cnt, step_amt;
  logic               load, step_en, kill;

  function automatic logic [XLEN-1:0] shift_fn(input shift_op_e sop, input logic [XLEN-1:0] d,
                                               input logic [SHAMT_W-1:0] s);
    logic signed [XLEN-1:0] ds;
    logic [XLEN-1:0]        r;
    ds = d;
    case (sop)
      SH_SLL:  r = d << s;
      SH_SRL:  r = d >> s;
      SH_SRA:  r = ds >>> s;
      SH_ROL:  r = (d << s) | (d >> (XLEN - int'(s)));
      SH_ROR:  r = (d >> s) | (d << (XLEN - int'(s)));
      default: r = d;
    endcase
    return r;
  endfunction

  assign step_amt = (cnt < STEP_C) ? cnt : STEP_C;
  // An operation change mid-flight is treated like a dropped request.
  assign kill     = abort | (op != op_q);
  assign q        = sreg;

  always_comb begin
    state_nx = state;
    load     = 1'b0;
    step_en  = 1'b0;
    done     = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start) begin
          load     = 1'b1;
          state_nx = (shamt == '0) ? ST_DONE : ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        if (kill) begin
          state_nx = ST_IDLE;
        end else begin
          step_en = 1'b1;
          if (cnt <= STEP_C) state_nx = ST_DONE;
        end
      end
      ST_DONE: begin
        done     = ~kill;
        state_nx = ST_IDLE;
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= ST_IDLE;
      op_q  <= SH_SLL;
      sreg  <= '0;
      cnt   <= '0;
    end else begin
      state <= state_nx;
      if (load) begin
        sreg <= data;
        cnt  <= shamt;
        op_q <= op;
      end else if (step_en) begin
        sreg <= shift_fn(op_q, sreg, step_amt);
        cnt  <= cnt - step_amt;
      end
    end
  end

endmodule

// File: rtl/alu_mc.sv
// Integer ALU for the multicycle core: single-cycle arithmetic/logic/compare,
// shifts either combinational or through the iterative shift unit.
module alu_mc
  import alu_mc_pkg::*;
#(
  parameter int XLEN       = 32,
  parameter int SHIFT_MODE = 1,
  parameter int SHIFT_STEP = 4,
  parameter int CTRL_W     = ALU_CTRL_WIDTH
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [XLEN-1:0]   a,
  input  logic [XLEN-1:0]   b,
  input  logic [CTRL_W-1:0] alucontrol,
  input  logic              alu_valid,
  output logic              alu_ready,
  output logic [XLEN-1:0]   result,
  output logic              zero
);

  localparam int SHAMT_W = $clog2(XLEN);
  localparam int DW      = XLEN + 1;

  logic [ALU_CTRL_WIDTH-1:0] ctrl;
  logic [XLEN:0]             sum, diff;
  logic                      eq, lt, ltu, is_shift, shift_done;
  logic [XLEN-1:0]           res_comb, shift_q;
  shift_op_e                 sop;

  function automatic logic [XLEN-1:0] barrel_fn(input shift_op_e op, input logic [XLEN-1:0] d,
                                                input logic [SHAMT_W-1:0] s);
    logic signed [XLEN-1:0] ds;
    logic [XLEN-1:0]        r;
    ds = d;
    case (op)
      SH_SLL:  r = d << s;
      SH_SRL:  r = d >> s;
      SH_SRA:  r = ds >>> s;
      SH_ROL:  r = (d << s) | (d >> (XLEN - int'(s)));
      SH_ROR:  r = (d >> s) | (d << (XLEN - int'(s)));
      default: r = d;
    endcase
    return r;
  endfunction

  assign ctrl = ALU_CTRL_WIDTH'(alucontrol);
  assign sum  = {1'b0, a} + {1'b0, b};
  assign diff = {1'b0, a} + {1'b0, ~b} + DW'(1);
  assign eq   = (a == b);
  // Carry out of a + ~b + 1 means a >= b unsigned; signed LT falls back to the sign bits when they differ.
  assign ltu  = ~diff[XLEN];
  assign lt   = (a[XLEN-1] ^ b[XLEN-1]) ? a[XLEN-1] : diff[XLEN-1];

  always_comb begin
    res_comb = '0;
    is_shift = 1'b0;
    sop      = SH_SLL;
    case (ctrl)
      ALU_CTRL_ADD:  res_comb = sum[XLEN-1:0];
      ALU_CTRL_SUB:  res_comb = diff[XLEN-1:0];
      ALU_CTRL_AND:  res_comb = a & b;
      ALU_CTRL_OR:   res_comb = a | b;
      ALU_CTRL_XOR:  res_comb = a ^ b;
      ALU_CTRL_SLT:  res_comb = XLEN'(lt);
      ALU_CTRL_SLTU: res_comb = XLEN'(ltu);
      ALU_CTRL_LUI:  res_comb = b;
      ALU_CTRL_BEQ:  res_comb = XLEN'(eq);
      ALU_CTRL_BNE:  res_comb = XLEN'(~eq);
      ALU_CTRL_BLT:  res_comb = XLEN'(lt);
      ALU_CTRL_BGE:  res_comb = XLEN'(~lt);
      ALU_CTRL_BLTU: res_comb = XLEN'(ltu);
      ALU_CTRL_BGEU: res_comb = XLEN'(~ltu);
      ALU_CTRL_MIN:  res_comb = lt  ? a : b;
      ALU_CTRL_MAX:  res_comb = lt  ? b : a;
      ALU_CTRL_MINU: res_comb = ltu ? a : b;
      ALU_CTRL_MAXU: res_comb = ltu ? b : a;
      ALU_CTRL_SLL:  begin is_shift = 1'b1; sop = SH_SLL; end
      ALU_CTRL_SRL:  begin is_shift = 1'b1; sop = SH_SRL; end
      ALU_CTRL_SRA:  begin is_shift = 1'b1; sop = SH_SRA; end
      ALU_CTRL_ROL:  begin is_shift = 1'b1; sop = SH_ROL; end
      ALU_CTRL_ROR:  begin is_shift = 1'b1; sop = SH_ROR; end
      default:       res_comb = '0;
    endcase
  end

  generate
    if (SHIFT_MODE == 1) begin : g_iter
      alu_shift_unit #(
        .XLEN       (XLEN),
        .SHIFT_STEP (SHIFT_STEP)
      ) u_shift (
        .clk   (clk),
        .reset (reset),
        .start (alu_valid & is_shift),
        .abort (~(alu_valid & is_shift)),
        .op    (sop),
        .data  (a),
        .shamt (b[SHAMT_W-1:0]),
        .done  (shift_done),
        .q     (shift_q)
      );
    end else begin : g_barrel
      logic unused_clk_rst;
      assign unused_clk_rst = clk ^ reset;
      assign shift_q        = barrel_fn(sop, a, b[SHAMT_W-1:0]);
      assign shift_done     = 1'b1;
    end
  endgenerate

  assign result    = is_shift ? shift_q : res_comb;
  assign alu_ready = alu_valid & (~is_shift | shift_done);
  assign zero      = (result == '0);

endmodule
